// File: rtl/id_frame_collector.sv
// Collects the nine per-state digits from the ID sequencer into one ID word and
// flags completed frames and out-of-order state jumps. Optional macro: ID_CHECK_EN.
module id_frame_collector #(
  parameter int NUM_DIGITS = 9
`ifdef ID_CHECK_EN
  , parameter logic [4*NUM_DIGITS-1:0] EXPECTED_ID = 36'h501085972
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              state_in,
  input  logic [3:0]              digit_in,
  output logic [4*NUM_DIGITS-1:0] id_word,
  output logic                    frame_valid,
  output logic                    seq_error,
  output logic [3:0]              digit_count,
  output logic                    busy
`ifdef ID_CHECK_EN
  , output logic                  id_match
`endif
);

  localparam int         W         = 4 * NUM_DIGITS;
  localparam logic [3:0] LAST_SLOT = 4'(NUM_DIGITS - 1);
  localparam logic [3:0] INVALID   = 4'b1110;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t         state_q;
  logic [3:0]     prev_q;
  // Holds at most the first NUM_DIGITS-1 digits; the last digit goes straight to id_word.
  logic [W-5:0]   asm_q;
  logic [W-1:0]   id_word_q;
  logic           frame_valid_q;
  logic           seq_error_q;
  logic [3:0]     digit_count_q;
  logic           busy_q;
  logic           evt;
  logic [W-1:0]   word_d;
`ifdef ID_CHECK_EN
  logic           id_match_q;
`endif

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    evt    = (state_in != prev_q);
    word_d = {asm_q, digit_in};
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      prev_q        <= INVALID;
      asm_q         <= '0;
      id_word_q     <= '0;
      frame_valid_q <= 1'b0;
      seq_error_q   <= 1'b0;
      digit_count_q <= 4'd0;
      busy_q        <= 1'b0;
`ifdef ID_CHECK_EN
      id_match_q    <= 1'b0;
`endif
    end else begin
      prev_q        <= state_in;
      frame_valid_q <= 1'b0;
      seq_error_q   <= 1'b0;
      if (evt) begin
        case (state_q)
          IDLE: begin
            if (state_in == 4'd0) begin
              asm_q         <= (W-4)'(digit_in);
              digit_count_q <= 4'd1;
              busy_q        <= 1'b1;
              state_q       <= COLLECT;
            end
          end
          COLLECT: begin
            if (state_in == digit_count_q) begin
              if (digit_count_q == LAST_SLOT) begin
                id_word_q     <= word_d;
                frame_valid_q <= 1'b1;
                asm_q         <= '0;
                digit_count_q <= 4'd0;
                busy_q        <= 1'b0;
                state_q       <= IDLE;
`ifdef ID_CHECK_EN
                id_match_q    <= (word_d == EXPECTED_ID);
`endif
              end else begin
                asm_q         <= word_d[W-5:0];
                digit_count_q <= digit_count_q + 4'd1;
              end
            end else begin
              // Out-of-order jump: discard the partial frame; a jump to 0 restarts at once.
              seq_error_q <= 1'b1;
              if (state_in == 4'd0) begin
                asm_q         <= (W-4)'(digit_in);
                digit_count_q <= 4'd1;
              end else begin
                asm_q         <= '0;
                digit_count_q <= 4'd0;
                busy_q        <= 1'b0;
                state_q       <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign id_word     = id_word_q;
  assign frame_valid = frame_valid_q;
  assign seq_error   = seq_error_q;
  assign digit_count = digit_count_q;
  assign busy        = busy_q;
`ifdef ID_CHECK_EN
  assign id_match    = id_match_q;
`else
  // Default build carries no reference comparator.
`endif

endmodule

// File: tb/tb_id_frame_collector.sv
// Directed bench for id_frame_collector: frame assembly, sequence errors,
// async reset and (with ID_CHECK_EN) the reference-ID comparison.
module tb_id_frame_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state_in;
  logic [3:0]  digit_in;
  logic [35:0] id_word;
  logic        frame_valid;
  logic        seq_error;
  logic [3:0]  digit_count;
  logic        busy;
`ifdef ID_CHECK_EN
  logic        id_match;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_frame_collector dut (
    .clk         (clk),
    .reset       (reset),
    .state_in    (state_in),
    .digit_in    (digit_in),
    .id_word     (id_word),
    .frame_valid (frame_valid),
    .seq_error   (seq_error),
    .digit_count (digit_count),
    .busy        (busy)
`ifdef ID_CHECK_EN
    , .id_match  (id_match)
`endif
  );

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present one state/digit pair, let one edge sample it, then settle past the edge.
  task automatic step(input logic [3:0] s, input logic [3:0] d);
    state_in = s;
    digit_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [35:0] w);
    for (int s = 0; s < 9; s++) step(4'(s), w[35-4*s -: 4]);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_id_word"},     id_word,           36'h0);
    check({tag, "_frame_valid"}, {35'h0, frame_valid}, 36'h0);
    check({tag, "_seq_error"},   {35'h0, seq_error},   36'h0);
    check({tag, "_digit_count"}, {32'h0, digit_count}, 36'h0);
    check({tag, "_busy"},        {35'h0, busy},        36'h0);
`ifdef ID_CHECK_EN
    check({tag, "_id_match"},    {35'h0, id_match},    36'h0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [35:0] word1;
    int          fv_cnt;
    int          se_cnt;
    int          busy_cnt;
    word1 = 36'h501085972;

    // Reset state, sequencer already sitting at state 0.
    reset    = 1'b1;
    state_in = 4'd0;
    digit_in = 4'd5;
    @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b0;

    // Full frame, each state held three cycles.
    for (int s = 0; s < 8; s++) begin
      for (int h = 0; h < 3; h++) step(4'(s), word1[35-4*s -: 4]);
      check($sformatf("t1_count_s%0d", s), {32'h0, digit_count}, 36'(s + 1));
      check($sformatf("t1_busy_s%0d", s),  {35'h0, busy},        36'h1);
    end
    step(4'd8, 4'd2);
    check("t1_frame_valid", {35'h0, frame_valid}, 36'h1);
    check("t1_id_word",     id_word,              36'h501085972);
    check("t1_count_done",  {32'h0, digit_count}, 36'h0);
    check("t1_busy_done",   {35'h0, busy},        36'h0);
    check("t1_no_error",    {35'h0, seq_error},   36'h0);
`ifdef ID_CHECK_EN
    check("t1_id_match",    {35'h0, id_match},    36'h1);
`endif
    step(4'd8, 4'd2);
    check("t1_fv_one_cycle", {35'h0, frame_valid}, 36'h0);

    // States 0,1,2,4: jump to a non-zero code aborts to IDLE.
    step(4'd0, 4'd1);
    step(4'd1, 4'd1);
    step(4'd2, 4'd1);
    step(4'd4, 4'd1);
    check("t2_seq_error", {35'h0, seq_error},   36'h1);
    check("t2_busy",      {35'h0, busy},        36'h0);
    check("t2_count",     {32'h0, digit_count}, 36'h0);
    check("t2_id_held",   id_word,              36'h501085972);
    step(4'd4, 4'd1);
    check("t2_err_one_cycle", {35'h0, seq_error}, 36'h0);

    // States 0,1,2,0: jump to 0 restarts the frame.
    step(4'd0, 4'd7);
    step(4'd1, 4'd7);
    step(4'd2, 4'd7);
    step(4'd0, 4'd1);
    check("t3_seq_error", {35'h0, seq_error},   36'h1);
    check("t3_count",     {32'h0, digit_count}, 36'h1);
    check("t3_busy",      {35'h0, busy},        36'h1);
    for (int s = 1; s < 9; s++) step(4'(s), 4'(s + 1));
    check("t3_frame_valid", {35'h0, frame_valid}, 36'h1);
    check("t3_no_error",    {35'h0, seq_error},   36'h0);
    check("t3_id_word",     id_word,              36'h123456789);
`ifdef ID_CHECK_EN
    check("t3_id_match",    {35'h0, id_match},    36'h0);
`endif

    // Reset, first state seen is 3: 3..8 ignored silently, then 0..8 completes once.
    #2;
    reset    = 1'b1;
    state_in = 4'd3;
    #2;
    check("t4_reset_id_word", id_word, 36'h0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    se_cnt = 0;
    busy_cnt = 0;
    fv_cnt = 0;
    for (int s = 3; s < 9; s++) begin
      step(4'(s), 4'hf);
      se_cnt   += int'(seq_error);
      busy_cnt += int'(busy);
      fv_cnt   += int'(frame_valid);
    end
    check("t4_no_error_3to8", 36'(se_cnt),   36'h0);
    check("t4_idle_3to8",     36'(busy_cnt), 36'h0);
    for (int s = 0; s < 9; s++) begin
      step(4'(s), 4'(9 - s));
      se_cnt += int'(seq_error);
      fv_cnt += int'(frame_valid);
    end
    check("t4_fv_pulses", 36'(fv_cnt), 36'h1);
    check("t4_no_error",  36'(se_cnt), 36'h0);
    check("t4_id_word",   id_word,     36'h987654321);

    // Reset mid-frame clears outputs without waiting for an edge.
    for (int s = 0; s < 6; s++) step(4'(s), 4'h6);
    check("t5_count_before", {32'h0, digit_count}, 36'h6);
    #2;
    reset = 1'b1;
    #1;
    check_cleared("t5_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(36'habcdef012);
    check("t5_frame_valid", {35'h0, frame_valid}, 36'h1);
    check("t5_id_word",     id_word,              36'habcdef012);

    // Correct reference ID, then the same with the state-6 digit corrupted.
    send_frame(36'h501085972);
    check("t6_id_word_ok", id_word, 36'h501085972);
`ifdef ID_CHECK_EN
    check("t6_id_match_ok", {35'h0, id_match}, 36'h1);
`endif
    send_frame(36'h501085372);
    check("t6_id_word_bad", id_word, 36'h501085372);
    check("t6_fv_bad",      {35'h0, frame_valid}, 36'h1);
`ifdef ID_CHECK_EN
    check("t6_id_match_bad", {35'h0, id_match}, 36'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
